// File: rtl/counter_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_run_ctrl_pkg
// Description : Shared types and constants for the counter run controller.
//               Holds the run FSM state encoding and the default width of
//               the wrap target / wrap tally.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_run_ctrl_pkg;

   // Default width of the wrap target and the wrap tally.
   localparam int c_WRAP_W_DEFAULT = 8;

   // Run controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage : counter_run_ctrl_pkg
`default_nettype wire

// File: rtl/counter_run_ctrl_wrap_tally.sv
`default_nettype none
// ============================================================================
// Module      : wrap_tally
// Description : WRAP_W-bit tally of counter wraps with synchronous clear and
//               increment, plus a compare flag that is high when the next
//               counted wrap is the final one (wraps == target - 1).
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset, clears the tally
//               clr    - clear tally to zero (wins over inc)
//               inc    - increment tally by one
//               target - latched wrap target to compare against
//               wraps  - current tally value
//               last   - high when wraps == target - 1
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_tally
   import counter_run_ctrl_pkg::*;
#(
   parameter int WRAP_W = c_WRAP_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   input  logic [WRAP_W-1:0] target,
   output logic [WRAP_W-1:0] wraps,
   output logic              last
);

   localparam logic [WRAP_W-1:0] c_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

   logic [WRAP_W-1:0] r_wraps;
   logic [WRAP_W-1:0] w_target_m1;

   // The tally never passes the target, so no saturation is needed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wraps <= '0;
      end else if (clr) begin
         r_wraps <= '0;
      end else if (inc) begin
         r_wraps <= r_wraps + c_ONE;
      end
   end

   assign w_target_m1 = target - c_ONE;
   assign last        = (r_wraps == w_target_m1);
   assign wraps       = r_wraps;

endmodule : wrap_tally
`default_nettype wire

// File: rtl/counter_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_run_ctrl
// Description : Run controller for an external 2-bit T-FF counter. Enables
//               the counter for a programmed number of wraps, supports pause
//               and abort, and reports completion and a zero-target error.
//               All outputs are decoded from registered state.
// Ports       : clk         - clock, rising edge
//               rst         - synchronous active-high reset
//               start       - run request, sampled in IDLE only
//               stop        - abort, honoured in RUN and PAUSE
//               hold        - pause request
//               wrap_target - wraps per run, latched on accepted start
//               cnt_y       - counter Moore output, high in counter state 11
//               x_en        - counter count enable, high only in RUN
//               busy        - high in RUN or PAUSE
//               done        - one-cycle completion pulse
//               err         - one-cycle pulse on start with zero target
//               wraps       - wraps counted in the current or last run
// Revision    : 1.0 - initial release
// ============================================================================
module counter_run_ctrl
   import counter_run_ctrl_pkg::*;
#(
   parameter int WRAP_W = c_WRAP_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              hold,
   input  logic [WRAP_W-1:0] wrap_target,
   input  logic              cnt_y,
   output logic              x_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [WRAP_W-1:0] wraps
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WRAP_W-1:0] r_target;
   logic              r_err;
   logic              w_err_nxt;
   logic              w_target_ld;
   logic              w_tally_clr;
   logic              w_tally_inc;
   logic              w_wrap_evt;
   logic              w_last;

   // The counter leaves 11 for 00 on this edge only while it is enabled.
   assign w_wrap_evt = (r_state == RUN) && cnt_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_target <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
         if (w_target_ld) begin
            r_target <= wrap_target;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = 1'b0;
      w_target_ld = 1'b0;
      w_tally_clr = 1'b0;
      w_tally_inc = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (wrap_target != '0) begin
                  w_target_ld = 1'b1;
                  w_tally_clr = 1'b1;
                  w_state_nxt = RUN;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            // Abort beats a coincident wrap; a wrap alongside hold still
            // counts because the counter was enabled on this edge.
            if (stop) begin
               w_state_nxt = IDLE;
            end else begin
               w_tally_inc = w_wrap_evt;
               if (w_wrap_evt && w_last) begin
                  w_state_nxt = DONE;
               end else if (hold) begin
                  w_state_nxt = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               w_state_nxt = IDLE;
            end else if (!hold) begin
               w_state_nxt = RUN;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   wrap_tally #(
      .WRAP_W (WRAP_W)
   ) u_wrap_tally (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_tally_clr),
      .inc    (w_tally_inc),
      .target (r_target),
      .wraps  (wraps),
      .last   (w_last)
   );

   assign x_en = (r_state == RUN);
   assign busy = (r_state == RUN) || (r_state == PAUSE);
   assign done = (r_state == DONE);
   assign err  = r_err;

endmodule : counter_run_ctrl
`default_nettype wire
